// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the shared single-port memory.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              dma_req;
  logic              dma_lock;
  logic [3:0]        dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [31:0]       dma_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port synchronous memory: CPU priority with DMA
// anti-starvation, bounded DMA burst locking, and a one-cycle read-return owner tag.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_LIM = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_dma_q, rd_dma_d;
  logic              cpu_win, dma_win;
  logic [ADDR_W-1:0] addr_mux;

  // Grant decision and next state; nothing is granted while reset is asserted
  always_comb begin
    cpu_win      = 1'b0;
    dma_win      = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          if (bus.cpu_req && bus.dma_req) begin
            if (starve_cnt_q == STARVE_TOP) dma_win = 1'b1;
            else                            cpu_win = 1'b1;
          end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
          end else if (bus.dma_req) begin
            dma_win = 1'b1;
          end
          if (dma_win && bus.dma_lock && (LOCK_MAX > 1)) begin
            state_d    = LOCKED;
            lock_cnt_d = LW'(1);
          end
        end
        LOCKED: begin
          if (bus.dma_req) begin
            dma_win    = 1'b1;
            lock_cnt_d = lock_cnt_q + 1'b1;
            if (!bus.dma_lock || (lock_cnt_d == LOCK_TOP)) begin
              state_d    = ARB;
              lock_cnt_d = '0;
            end
          end else begin
            // DMA walked away: lock ends and the CPU may use the idle slot
            cpu_win    = bus.cpu_req;
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end
        default: state_d = ARB;
      endcase
      if (dma_win) begin
        starve_cnt_d = '0;
      end else if (bus.dma_req && cpu_win && (starve_cnt_q != STARVE_TOP)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_vld_d = (cpu_win && (bus.cpu_we == 4'b0000)) || (dma_win && (bus.dma_we == 4'b0000));
    rd_dma_d = dma_win;
  end

  // Stage boundary: control state and read-return tag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_dma_q <= rd_dma_d;
  end

  assign addr_mux = dma_win ? bus.dma_addr : bus.cpu_addr;

  assign bus.mem_en     = cpu_win | dma_win;
  assign bus.mem_we     = dma_win ? bus.dma_we : (cpu_win ? bus.cpu_we : 4'b0000);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_din    = dma_win ? bus.dma_wdata : bus.cpu_wdata;

  assign bus.cpu_stall  = rst & bus.cpu_req & ~cpu_win;
  assign bus.dma_gnt    = dma_win;
  assign bus.cpu_rvalid = rst & rd_vld_q & ~rd_dma_q;
  assign bus.dma_rvalid = rst & rd_vld_q & rd_dma_q;
  assign bus.cpu_rdata  = bus.mem_dout;
  assign bus.dma_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single reads/writes, contention,
// locked bursts, early unlock, interleaved read returns and reset mid-lock.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(14)) bus ();

  mem_port_arbiter #(
    .ADDR_W(14),
    .STARVE_LIM(4),
    .LOCK_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req  = 1'b0;
    bus.dma_req  = 1'b0;
    bus.dma_lock = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 4'h0;
    bus.cpu_addr  = 14'h0;
    bus.cpu_wdata = 32'h0;
    bus.dma_req   = 1'b1;
    bus.dma_lock  = 1'b1;
    bus.dma_we    = 4'h0;
    bus.dma_addr  = 14'h0;
    bus.dma_wdata = 32'h0;
    bus.mem_dout  = 32'h0;

    // Reset with both requesting: all outputs quiet
    next_cycle();
    next_cycle();
    #2;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();

    // CPU-only read
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 4'h0;
    bus.cpu_addr = 14'h010;
    #2;
    chk("rd_cpu_stall", bus.cpu_stall, 0);
    chk("rd_mem_en", bus.mem_en, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h010);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_dma_gnt", bus.dma_gnt, 0);
    next_cycle();
    idle();
    bus.mem_dout = 32'hDEADBEEF;
    #2;
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid", bus.dma_rvalid, 0);
    chk("rd_idle_mem_en", bus.mem_en, 0);
    next_cycle();
    #2;
    chk("rd_rvalid_drop", bus.cpu_rvalid, 0);

    // CPU write: byte enables and data pass through, no read return
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 4'hF;
    bus.cpu_addr  = 14'h020;
    bus.cpu_wdata = 32'h12345678;
    #2;
    chk("wr_mem_we", bus.mem_we, 32'hF);
    chk("wr_mem_din", bus.mem_din, 32'h12345678);
    next_cycle();
    idle();
    bus.cpu_we = 4'h0;
    #2;
    chk("wr_no_rvalid", bus.cpu_rvalid, 0);
    next_cycle();

    // Contention: CPU wins four, DMA the fifth, repeat; read returns follow the winner
    bus.cpu_req  = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_lock = 1'b0;
    bus.cpu_addr = 14'h100;
    bus.dma_addr = 14'h200;
    for (int i = 0; i < 10; i++) begin
      logic exp_dma;
      exp_dma = ((i % 5) == 4);
      #2;
      chk($sformatf("cont_dma_gnt_%0d", i), bus.dma_gnt, exp_dma);
      chk($sformatf("cont_cpu_stall_%0d", i), bus.cpu_stall, exp_dma);
      chk($sformatf("cont_mem_addr_%0d", i), bus.mem_addr, exp_dma ? 32'h200 : 32'h100);
      if (i > 0) begin
        chk($sformatf("cont_cpu_rvalid_%0d", i), bus.cpu_rvalid, ((i - 1) % 5) != 4);
        chk($sformatf("cont_dma_rvalid_%0d", i), bus.dma_rvalid, ((i - 1) % 5) == 4);
      end
      next_cycle();
    end
    idle();
    next_cycle();

    // Lock: four CPU wins, then an 8-beat locked DMA burst, then CPU again
    bus.cpu_req  = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_lock = 1'b1;
    bus.dma_we   = 4'hF;
    for (int i = 0; i < 13; i++) begin
      logic exp_dma;
      exp_dma = (i >= 4) && (i <= 11);
      #2;
      chk($sformatf("lock_dma_gnt_%0d", i), bus.dma_gnt, exp_dma);
      chk($sformatf("lock_cpu_stall_%0d", i), bus.cpu_stall, exp_dma);
      next_cycle();
    end
    idle();
    next_cycle();
    // DMA-only grant clears the starvation count
    bus.dma_req = 1'b1;
    #2;
    chk("clr1_dma_gnt", bus.dma_gnt, 1);
    next_cycle();

    // Early unlock on the third beat
    bus.dma_req  = 1'b1;
    bus.dma_lock = 1'b1;
    bus.cpu_req  = 1'b0;
    #2;
    chk("eu_beat1", bus.dma_gnt, 1);
    next_cycle();
    bus.cpu_req = 1'b1;
    #2;
    chk("eu_beat2_gnt", bus.dma_gnt, 1);
    chk("eu_beat2_stall", bus.cpu_stall, 1);
    next_cycle();
    bus.dma_lock = 1'b0;
    #2;
    chk("eu_beat3_gnt", bus.dma_gnt, 1);
    chk("eu_beat3_stall", bus.cpu_stall, 1);
    next_cycle();
    bus.dma_lock = 1'b1;
    #2;
    chk("eu_after_dma_gnt", bus.dma_gnt, 0);
    chk("eu_after_cpu_stall", bus.cpu_stall, 0);
    next_cycle();
    idle();
    next_cycle();
    bus.dma_req = 1'b1;
    #2;
    chk("clr2_dma_gnt", bus.dma_gnt, 1);
    next_cycle();

    // Interleaved reads: DMA then CPU, returns in order, never together
    bus.dma_req  = 1'b1;
    bus.dma_lock = 1'b0;
    bus.dma_we   = 4'h0;
    bus.dma_addr = 14'h004;
    bus.cpu_req  = 1'b0;
    #2;
    chk("il_dma_gnt", bus.dma_gnt, 1);
    chk("il_dma_addr", bus.mem_addr, 32'h004);
    next_cycle();
    bus.dma_req  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 4'h0;
    bus.cpu_addr = 14'h008;
    bus.mem_dout = 32'hA5A50004;
    #2;
    chk("il_dma_rvalid", bus.dma_rvalid, 1);
    chk("il_cpu_rvalid_lo", bus.cpu_rvalid, 0);
    chk("il_dma_rdata", bus.dma_rdata, 32'hA5A50004);
    chk("il_cpu_addr", bus.mem_addr, 32'h008);
    chk("il_cpu_stall", bus.cpu_stall, 0);
    next_cycle();
    idle();
    bus.mem_dout = 32'h00000008;
    #2;
    chk("il_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("il_dma_rvalid_lo", bus.dma_rvalid, 0);
    chk("il_cpu_rdata", bus.cpu_rdata, 32'h00000008);
    next_cycle();
    #2;
    chk("il_quiet_cpu", bus.cpu_rvalid, 0);
    chk("il_quiet_dma", bus.dma_rvalid, 0);

    // Reset in the middle of a locked DMA read burst
    bus.dma_req  = 1'b1;
    bus.dma_lock = 1'b1;
    bus.dma_we   = 4'h0;
    #2;
    chk("rml_grant", bus.dma_gnt, 1);
    next_cycle();
    bus.cpu_req = 1'b1;
    #2;
    chk("rml_locked_gnt", bus.dma_gnt, 1);
    next_cycle();
    rst = 1'b0;
    #2;
    chk("rml_rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rml_rst_dma_gnt", bus.dma_gnt, 0);
    chk("rml_rst_cpu_stall", bus.cpu_stall, 0);
    chk("rml_rst_mem_en", bus.mem_en, 0);
    chk("rml_rst_mem_we", bus.mem_we, 0);
    next_cycle();
    rst = 1'b1;
    #2;
    chk("rml_post_dma_rvalid", bus.dma_rvalid, 0);
    chk("rml_post_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rml_post_dma_gnt", bus.dma_gnt, 0);
    chk("rml_post_cpu_stall", bus.cpu_stall, 0);
    chk("rml_post_mem_en", bus.mem_en, 1);
    next_cycle();
    idle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
